// File: rtl/stim_scheduler.sv
// stim_scheduler
//   Closed-loop stimulation sequencer. A per-window majority-vote detection
//   is debounced over CONF_CNT consecutive valid positive windows. A
//   confirmed event then produces a burst of N_PULSES pulses: ON_CYC high,
//   OFF_CYC low between pulses. A REFRACT_CYC hold-off follows, during which
//   detections are ignored.
//
// Ports
//   clk_i          system clock
//   rst_i          synchronous active-high reset
//   en_i           scheduler enable (gates entry into and progress of confirmation)
//   det_i          majority-vote detection flag
//   det_valid_i    det_i is meaningful only while this is high
//   abort_i        immediate burst cancel, no refractory
//   stim_out_o     registered stimulator drive
//   busy_o         high whenever the scheduler is not idle
//   burst_start_o  one-cycle pulse on entry to the first pulse of a burst
//   pulse_idx_o    0-based pulse number within the burst, 0 when idle
//   event_cnt_o    saturating confirmed-burst count
//
// Optional feature macro: STIM_EVENT_CNT_EN
//   Defined   : event_cnt_o counts burst starts, saturates at 16'hFFFF, rst only clears it.
//   Undefined : event_cnt_o is tied to zero and no counter is built.
module stim_scheduler #(
  parameter int CONF_CNT    = 4,
  parameter int N_PULSES    = 8,
  parameter int ON_CYC      = 100,
  parameter int OFF_CYC     = 400,
  parameter int REFRACT_CYC = 50000,
  parameter int CNT_W       = 20,
  localparam int PIDX_W     = $clog2(N_PULSES + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic              det_i,
  input  logic              det_valid_i,
  input  logic              abort_i,
  output logic              stim_out_o,
  output logic              busy_o,
  output logic              burst_start_o,
  output logic [PIDX_W-1:0] pulse_idx_o,
  output logic [15:0]       event_cnt_o
);

  localparam int CONF_W = $clog2(CONF_CNT + 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_CONFIRM   = 3'd1;
  localparam logic [2:0] S_PULSE_ON  = 3'd2;
  localparam logic [2:0] S_PULSE_OFF = 3'd3;
  localparam logic [2:0] S_REFRACT   = 3'd4;

  // Timers load value-1 so a phase lasts exactly value cycles.
  localparam logic [CNT_W-1:0]  ON_LOAD   = CNT_W'(ON_CYC - 1);
  localparam logic [CNT_W-1:0]  OFF_LOAD  = CNT_W'(OFF_CYC - 1);
  localparam logic [CNT_W-1:0]  REF_LOAD  = CNT_W'(REFRACT_CYC - 1);
  localparam logic [CNT_W-1:0]  TIMER_Z   = {CNT_W{1'b0}};
  localparam logic [CONF_W-1:0] CONF_Z    = {CONF_W{1'b0}};
  localparam logic [CONF_W-1:0] CONF_ONE  = CONF_W'(1);
  localparam logic [CONF_W-1:0] CONF_LAST = CONF_W'(CONF_CNT - 1);
  localparam logic [PIDX_W-1:0] PIDX_Z    = {PIDX_W{1'b0}};
  localparam logic [PIDX_W-1:0] PIDX_LAST = PIDX_W'(N_PULSES - 1);

  logic [2:0]        state_q, state_d;
  logic [CONF_W-1:0] conf_q, conf_d;
  logic [CNT_W-1:0]  timer_q, timer_d;
  logic [PIDX_W-1:0] pidx_q, pidx_d;
  logic              start_d;
  logic              stim_q, busy_q, bstart_q;
  logic              qualify_s;

  assign qualify_s = en_i & det_valid_i & det_i;

  // Next-state logic: abort overrides every normal transition.
  always_comb begin
    state_d = state_q;
    conf_d  = conf_q;
    timer_d = timer_q;
    pidx_d  = pidx_q;
    start_d = 1'b0;
    if (abort_i) begin
      // Abort in IDLE is a no-op, including suppressing a qualifying detection.
      if (state_q != S_IDLE) begin
        state_d = S_IDLE;
        conf_d  = CONF_Z;
        timer_d = TIMER_Z;
        pidx_d  = PIDX_Z;
      end else begin
        state_d = S_IDLE;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (qualify_s) begin
            if (CONF_CNT == 1) begin
              state_d = S_PULSE_ON;
              timer_d = ON_LOAD;
              pidx_d  = PIDX_Z;
              conf_d  = CONF_Z;
              start_d = 1'b1;
            end else begin
              state_d = S_CONFIRM;
              conf_d  = CONF_ONE;
            end
          end else begin
            state_d = S_IDLE;
          end
        end
        S_CONFIRM: begin
          if (!en_i) begin
            state_d = S_IDLE;
            conf_d  = CONF_Z;
          end else if (!det_valid_i) begin
            // Invalid windows neither count nor break the run.
            state_d = S_CONFIRM;
          end else if (det_i) begin
            if (conf_q == CONF_LAST) begin
              state_d = S_PULSE_ON;
              timer_d = ON_LOAD;
              pidx_d  = PIDX_Z;
              conf_d  = CONF_Z;
              start_d = 1'b1;
            end else begin
              conf_d = conf_q + CONF_ONE;
            end
          end else begin
            state_d = S_IDLE;
            conf_d  = CONF_Z;
          end
        end
        S_PULSE_ON: begin
          if (timer_q != TIMER_Z) begin
            timer_d = timer_q - 1'b1;
          end else if (pidx_q < PIDX_LAST) begin
            state_d = S_PULSE_OFF;
            timer_d = OFF_LOAD;
          end else begin
            // Last pulse: no trailing OFF gap.
            state_d = S_REFRACT;
            timer_d = REF_LOAD;
          end
        end
        S_PULSE_OFF: begin
          if (timer_q != TIMER_Z) begin
            timer_d = timer_q - 1'b1;
          end else begin
            state_d = S_PULSE_ON;
            timer_d = ON_LOAD;
            pidx_d  = pidx_q + 1'b1;
          end
        end
        S_REFRACT: begin
          if (timer_q != TIMER_Z) begin
            timer_d = timer_q - 1'b1;
          end else begin
            state_d = S_IDLE;
            pidx_d  = PIDX_Z;
          end
        end
        default: begin
          state_d = S_IDLE;
          conf_d  = CONF_Z;
          timer_d = TIMER_Z;
          pidx_d  = PIDX_Z;
        end
      endcase
    end
  end

  // State and registered outputs; outputs are decoded from next state so they align with it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      conf_q   <= CONF_Z;
      timer_q  <= TIMER_Z;
      pidx_q   <= PIDX_Z;
      stim_q   <= 1'b0;
      busy_q   <= 1'b0;
      bstart_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      conf_q   <= conf_d;
      timer_q  <= timer_d;
      pidx_q   <= pidx_d;
      stim_q   <= (state_d == S_PULSE_ON);
      busy_q   <= (state_d != S_IDLE);
      bstart_q <= start_d;
    end
  end

  assign stim_out_o    = stim_q;
  assign busy_o        = busy_q;
  assign burst_start_o = bstart_q;
  assign pulse_idx_o   = pidx_q;

`ifdef STIM_EVENT_CNT_EN
  logic [15:0] event_cnt_q, event_cnt_d;

  // Saturating burst counter; abort does not clear it.
  always_comb begin
    event_cnt_d = event_cnt_q;
    if (start_d && (event_cnt_q != 16'hFFFF)) begin
      event_cnt_d = event_cnt_q + 16'd1;
    end else begin
      event_cnt_d = event_cnt_q;
    end
  end

  // Event counter register, cleared only by reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      event_cnt_q <= 16'd0;
    end else begin
      event_cnt_q <= event_cnt_d;
    end
  end

  assign event_cnt_o = event_cnt_q;
`else
  assign event_cnt_o = 16'd0;
`endif

endmodule
